qspi_psram_responder: RTL and testbench

//   Synthesizable QSPI PSRAM target: the device end of the SoC's shared flash/PSRAM SPI bus.

---
 rtl/qspi_psram_responder.sv | 197 +++++++++++++++++++
 tb/tb_qspi_psram_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_psram_responder.sv
// QSPI PSRAM target: oversamples cs_n/sclk/io on clk and serves single/quad
// reads and writes from an internal byte array.
module qspi_psram_responder #(
    parameter int DEPTH     = 1024,
    parameter int QRD_DUMMY = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_cs_n,
    input  logic       spi_sclk,
    input  logic [3:0] spi_io_in,
    output logic [3:0] spi_io_out,
    output logic [3:0] spi_io_oe,
    output logic       cmd_done,
    output logic       bad_cmd
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [4:0] DUMMY_LAST = 5'(QRD_DUMMY > 0 ? QRD_DUMMY - 1 : 0);
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_QREAD  = 8'hEB;
    localparam logic [7:0] OP_QWRITE = 8'h38;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE
    } state_t;

    state_t state_q, state_d;

    logic       cs_n_p0, cs_n_p1, cs_n_p2;
    logic       sclk_p0, sclk_p1, sclk_p2;
    logic [3:0] io_p0, io_p1;
    logic       cs_rise, cs_fall, rise_ev, fall_ev;

    logic [4:0]    cnt;
    logic          quad_q;
    logic          read_q;
    logic [7:0]    cmd_sr, rd_sr, wr_sr;
    logic [AW-1:0] addr;
    logic [7:0]    mem [DEPTH];

    logic [7:0]    opcode, wr_next;
    logic [AW-1:0] addr_cur;
    logic          op_known, op_quad, op_read, addr_last, byte_last;

    // Synchroniser stage boundary; cs_n resets to the asserted level so a
    // transfer still in progress after reset is not mistaken for a new one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_n_p0 <= 1'b0;
            cs_n_p1 <= 1'b0;
            cs_n_p2 <= 1'b0;
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
        end else begin
            cs_n_p0 <= spi_cs_n;
            cs_n_p1 <= cs_n_p0;
            cs_n_p2 <= cs_n_p1;
            sclk_p0 <= spi_sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
        end
    end

    always_ff @(posedge clk) begin
        io_p0 <= spi_io_in;
        io_p1 <= io_p0;
    end

    assign cs_rise = cs_n_p1 & ~cs_n_p2;
    assign cs_fall = ~cs_n_p1 & cs_n_p2;
    assign rise_ev = sclk_p1 & ~sclk_p2 & ~cs_n_p1;
    assign fall_ev = ~sclk_p1 & sclk_p2 & ~cs_n_p1;

    always_comb begin
        opcode    = (cmd_sr << 1) | {7'd0, io_p1[0]};
        op_known  = (opcode == OP_READ) || (opcode == OP_WRITE) ||
                    (opcode == OP_QREAD) || (opcode == OP_QWRITE);
        op_quad   = (opcode == OP_QREAD) || (opcode == OP_QWRITE);
        op_read   = (opcode == OP_READ) || (opcode == OP_QREAD);
        addr_cur  = quad_q ? ((addr << 4) | AW'(io_p1)) : ((addr << 1) | AW'(io_p1[0]));
        wr_next   = quad_q ? ((wr_sr << 4) | {4'd0, io_p1}) : ((wr_sr << 1) | {7'd0, io_p1[0]});
        addr_last = quad_q ? (cnt == 5'd5) : (cnt == 5'd23);
        byte_last = quad_q ? (cnt == 5'd1) : (cnt == 5'd7);
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (cs_fall) state_d = S_CMD;
                S_CMD:   if (rise_ev && cnt == 5'd7) state_d = op_known ? S_ADDR : S_IGNORE;
                S_ADDR: begin
                    if (rise_ev && addr_last) begin
                        if (!read_q)
                            state_d = S_WDATA;
                        else if (quad_q && QRD_DUMMY > 0)
                            state_d = S_DUMMY;
                        else
                            state_d = S_RDATA;
                    end
                end
                S_DUMMY: if (rise_ev && cnt == DUMMY_LAST) state_d = S_RDATA;
                default: state_d = state_q;
            endcase
        end
    end

    // Control stage boundary: state, counters, flags and registered pad drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt        <= 5'd0;
            quad_q     <= 1'b0;
            read_q     <= 1'b0;
            cmd_done   <= 1'b0;
            bad_cmd    <= 1'b0;
            spi_io_out <= 4'd0;
            spi_io_oe  <= 4'd0;
        end else begin
            state_q  <= state_d;
            cmd_done <= cs_rise && (state_q inside {S_ADDR, S_DUMMY, S_RDATA, S_WDATA});
            if (cs_rise) begin
                spi_io_out <= 4'd0;
                spi_io_oe  <= 4'd0;
            end else if (fall_ev && state_q == S_RDATA) begin
                spi_io_out <= quad_q ? rd_sr[7:4] : {2'b00, rd_sr[7], 1'b0};
                spi_io_oe  <= quad_q ? 4'b1111 : 4'b0010;
                cnt        <= byte_last ? 5'd0 : cnt + 5'd1;
            end
            if (state_q == S_IDLE && cs_fall)
                cnt <= 5'd0;
            if (rise_ev) begin
                case (state_q)
                    S_CMD: begin
                        cnt <= (cnt == 5'd7) ? 5'd0 : cnt + 5'd1;
                        if (cnt == 5'd7) begin
                            quad_q <= op_quad;
                            read_q <= op_read;
                            if (!op_known)
                                bad_cmd <= 1'b1;
                        end
                    end
                    S_ADDR, S_DUMMY: cnt <= (state_d != state_q) ? 5'd0 : cnt + 5'd1;
                    S_WDATA:         cnt <= byte_last ? 5'd0 : cnt + 5'd1;
                    default:         cnt <= cnt;
                endcase
            end
        end
    end

    // Datapath stage boundary: shift registers, address pointer and prefetch.
    always_ff @(posedge clk) begin
        if (rise_ev) begin
            case (state_q)
                S_CMD: cmd_sr <= opcode;
                S_ADDR: begin
                    if (state_d == S_RDATA) begin
                        rd_sr <= mem[addr_cur];
                        addr  <= addr_cur + AW'(1);
                    end else begin
                        addr  <= addr_cur;
                    end
                end
                S_DUMMY: begin
                    if (state_d == S_RDATA) begin
                        rd_sr <= mem[addr];
                        addr  <= addr + AW'(1);
                    end
                end
                S_WDATA: begin
                    wr_sr <= wr_next;
                    if (byte_last)
                        addr <= addr + AW'(1);
                end
                default: ;
            endcase
        end else if (fall_ev && state_q == S_RDATA) begin
            // The last bit of a byte is already on the pads; fetch the next one.
            if (byte_last) begin
                rd_sr <= mem[addr];
                addr  <= addr + AW'(1);
            end else begin
                rd_sr <= quad_q ? (rd_sr << 4) : (rd_sr << 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rise_ev && state_q == S_WDATA && byte_last)
            mem[addr] <= wr_next;
    end

endmodule

// File: tb/tb_qspi_psram_responder.sv
// Bench for qspi_psram_responder: an SPI master driving random transfers,
// with a byte-array reference model and a per-cycle pad monitor.
module tb_qspi_psram_responder;
    localparam int DEPTH     = 1024;
    localparam int QRD_DUMMY = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_cs_n = 1'b1;
    logic       spi_sclk = 1'b0;
    logic [3:0] spi_io_in = 4'd0;
    logic [3:0] spi_io_out, spi_io_oe;
    logic       cmd_done, bad_cmd;

    qspi_psram_responder #(.DEPTH(DEPTH), .QRD_DUMMY(QRD_DUMMY)) dut (
        .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_io_in(spi_io_in), .spi_io_out(spi_io_out), .spi_io_oe(spi_io_oe),
        .cmd_done(cmd_done), .bad_cmd(bad_cmd)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         h       = 4;
    logic       mon_en  = 1'b0;
    logic [3:0] exp_io  = 4'd0;
    logic [3:0] exp_oe  = 4'd0;
    logic       exp_bad = 1'b0;
    logic [7:0] mdl [DEPTH];
    logic [7:0] wr_q [$];
    logic [7:0] rd_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pads must hold the model's value from 3 clk after a fall until past the next rise.
    always @(negedge clk) begin
        if (mon_en) begin
            n_tests++;
            if (spi_io_oe !== exp_oe || (exp_oe != 4'd0 && spi_io_out !== exp_io)) begin
                n_fail++;
                $display("FAIL io_mon t=%0t: got oe=%h io=%h expected oe=%h io=%h",
                         $time, spi_io_oe, spi_io_out, exp_oe, exp_io);
            end
        end
    end

    task automatic sclk_cycle(input logic [3:0] drive, input logic [3:0] e_io,
                              input logic [3:0] e_oe, output logic [3:0] got);
        spi_io_in = drive;
        repeat (3) @(negedge clk);
        exp_io = e_io;
        exp_oe = e_oe;
        mon_en = 1'b1;
        repeat (h - 3) @(negedge clk);
        got = spi_io_out;
        spi_sclk = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        repeat (h - 2) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    // One transfer; cut = data unit index at which cs_n rises early,
    // rst_at = data unit index at which rst is pulsed (-1 disables either).
    task automatic do_txn(input logic [7:0] op, input int a, input int nbytes,
                          input int cut, input int rst_at);
        logic        known, quad, rd, stop, did_rst;
        logic [3:0]  got, nib;
        logic [7:0]  b, asm;
        logic [23:0] a24;
        int          u_per, unit, ad, pulses;
        known   = (op == 8'h02) || (op == 8'h03) || (op == 8'hEB) || (op == 8'h38);
        quad    = (op == 8'hEB) || (op == 8'h38);
        rd      = (op == 8'h03) || (op == 8'hEB);
        u_per   = quad ? 2 : 8;
        stop    = 1'b0;
        did_rst = 1'b0;
        unit    = 0;
        rd_q.delete();
        spi_cs_n = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        for (int i = 0; i < 8; i++)
            sclk_cycle({3'b000, op[7-i]}, 4'd0, 4'd0, got);
        if (!known) begin
            exp_bad = 1'b1;
            for (int i = 0; i < 8; i++)
                sclk_cycle(4'($urandom_range(0, 15)), 4'd0, 4'd0, got);
        end else begin
            a24 = 24'(a);
            if (quad) begin
                for (int i = 0; i < 6; i++)
                    sclk_cycle(a24[23-4*i -: 4], 4'd0, 4'd0, got);
            end else begin
                for (int i = 0; i < 24; i++)
                    sclk_cycle({3'b000, a24[23-i]}, 4'd0, 4'd0, got);
            end
            if (op == 8'hEB)
                for (int i = 0; i < QRD_DUMMY; i++)
                    sclk_cycle(4'd0, 4'd0, 4'd0, got);
            for (int i = 0; i < nbytes && !stop; i++) begin
                ad  = (a + i) % DEPTH;
                b   = rd ? mdl[ad] : wr_q[i];
                asm = 8'd0;
                for (int k = 0; k < u_per && !stop; k++) begin
                    nib = (k == 0) ? b[7:4] : b[3:0];
                    if (unit == cut) begin
                        stop = 1'b1;
                    end else if (unit == rst_at) begin
                        repeat (3) @(negedge clk);
                        check("pre_rst_oe", 32'(spi_io_oe), quad ? 32'hF : 32'h2);
                        rst = 1'b1;
                        #1;
                        check("rst_oe", 32'(spi_io_oe), 32'h0);
                        check("rst_io", 32'(spi_io_out), 32'h0);
                        repeat (3) @(negedge clk);
                        rst = 1'b0;
                        exp_bad = 1'b0;
                        stop = 1'b1;
                        did_rst = 1'b1;
                    end else begin
                        if (rd) begin
                            sclk_cycle(4'd0, quad ? nib : {2'b00, b[7-k], 1'b0},
                                       quad ? 4'hF : 4'h2, got);
                            asm = quad ? {asm[3:0], got} : {asm[6:0], got[1]};
                        end else begin
                            sclk_cycle(quad ? nib : {3'b000, b[7-k]}, 4'd0, 4'd0, got);
                        end
                        unit++;
                    end
                end
                if (!stop) begin
                    if (rd) begin
                        check("rd_byte", 32'(asm), 32'(b));
                        rd_q.push_back(asm);
                    end else begin
                        mdl[ad] = b;
                    end
                end
            end
        end
        repeat ($urandom_range(1, 5)) @(negedge clk);
        spi_cs_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (cmd_done) pulses++;
        end
        if (!did_rst)
            check("cmd_done_pulses", 32'(pulses), known ? 32'd1 : 32'd0);
        check("idle_oe", 32'(spi_io_oe), 32'h0);
        check("bad_cmd", 32'(bad_cmd), 32'(exp_bad));
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [7:0] pre20;
        logic [7:0] ops [4];
        logic [7:0] op;
        int         n;
        ops[0] = 8'h02; ops[1] = 8'h03; ops[2] = 8'hEB; ops[3] = 8'h38;

        repeat (3) @(negedge clk);
        check("reset_io_out", 32'(spi_io_out), 32'h0);
        check("reset_oe", 32'(spi_io_oe), 32'h0);
        check("reset_cmd_done", 32'(cmd_done), 32'h0);
        check("reset_bad_cmd", 32'(bad_cmd), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Give the whole array known contents.
        h = 4;
        wr_q.delete();
        for (int i = 0; i < DEPTH; i++) wr_q.push_back(8'($urandom_range(0, 255)));
        do_txn(8'h38, 0, DEPTH, -1, -1);

        // T1
        wr_q = '{8'hA5, 8'h3C};
        do_txn(8'h02, 'h10, 2, -1, -1);
        do_txn(8'h03, 'h10, 2, -1, -1);
        check("t1_len", 32'(rd_q.size()), 32'd2);
        if (rd_q.size() == 2) begin
            check("t1_byte0", 32'(rd_q[0]), 32'hA5);
            check("t1_byte1", 32'(rd_q[1]), 32'h3C);
        end

        // T2
        wr_q = '{8'h11, 8'h22, 8'h33};
        do_txn(8'h38, 'h3FE, 3, -1, -1);
        check("t2_model_wrap", 32'(mdl[0]), 32'h33);
        do_txn(8'hEB, 'h3FE, 3, -1, -1);
        check("t2_len", 32'(rd_q.size()), 32'd3);
        if (rd_q.size() == 3) begin
            check("t2_byte0", 32'(rd_q[0]), 32'h11);
            check("t2_byte1", 32'(rd_q[1]), 32'h22);
            check("t2_byte2", 32'(rd_q[2]), 32'h33);
        end

        // T4
        do_txn(8'h9F, 0, 0, -1, -1);
        check("t4_bad_cmd", 32'(bad_cmd), 32'h1);
        do_txn(8'h03, 'h10, 1, -1, -1);
        if (rd_q.size() == 1) check("t4_read", 32'(rd_q[0]), 32'hA5);
        else check("t4_len", 32'(rd_q.size()), 32'd1);
        check("t4_bad_sticky", 32'(bad_cmd), 32'h1);

        // T3
        pre20 = mdl['h20];
        wr_q = '{8'h5A};
        do_txn(8'h02, 'h20, 1, 5, -1);
        do_txn(8'h03, 'h20, 1, -1, -1);
        if (rd_q.size() == 1) check("t3_unchanged", 32'(rd_q[0]), 32'(pre20));
        else check("t3_len", 32'(rd_q.size()), 32'd1);

        // T5
        do_txn(8'hEB, 'h10, 3, -1, 4);
        check("t5_bad_cleared", 32'(bad_cmd), 32'h0);
        do_txn(8'h03, 'h10, 2, -1, -1);
        if (rd_q.size() == 2) begin
            check("t5_byte0", 32'(rd_q[0]), 32'hA5);
            check("t5_byte1", 32'(rd_q[1]), 32'h3C);
        end else begin
            check("t5_len", 32'(rd_q.size()), 32'd2);
        end

        // T6: random traffic at clk/8 and clk/16
        for (int t = 0; t < 24; t++) begin
            h  = ($urandom_range(0, 1) == 0) ? 4 : 8;
            op = ops[$urandom_range(0, 3)];
            n  = $urandom_range(1, 4);
            wr_q.delete();
            for (int i = 0; i < n; i++) wr_q.push_back(8'($urandom_range(0, 255)));
            do_txn(op, int'($urandom_range(0, DEPTH - 1)), n, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
